// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one 256x4 data memory between two requesters, with
//   round-robin grant and per-port lock so one port can keep ownership.
// Latency: req seen in IDLE at cycle N -> memory access at N+1, ack at N+2.
// Backpressure: req is held until ack. A non-eligible or losing port waits.
// Ports:
//   clk, rst                    clock and async active-high reset
//   reqN/weN/addrN/wdataN/lockN request side of port N (N = 0, 1)
//   ackN, rdataN                one-cycle completion pulse, registered read data
//   mem_we/mem_addr/mem_wdata   memory pins driven by the arbiter
//   mem_rdata                   combinational memory read data
module dmem_arbiter #(
  parameter int AW = 8,
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  input  logic          lock0,
  input  logic          lock1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          win_q, win_d;        // port being served
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          last_q, last_d;      // port served most recently
  logic          own_vld_q, own_vld_d;
  logic          own_q, own_d;        // lock owner, meaningful when own_vld_q
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;

  logic elig0, elig1, pick;

  // A recorded lock owner excludes the other port entirely.
  assign elig0 = req0 & (~own_vld_q | ~own_q);
  assign elig1 = req1 & (~own_vld_q |  own_q);
  // On a tie, the port not served last wins.
  assign pick  = (elig0 & elig1) ? ~last_q : elig1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      win_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      last_q    <= 1'b1;
      own_vld_q <= 1'b0;
      own_q     <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      last_q    <= last_d;
      own_vld_q <= own_vld_d;
      own_q     <= own_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    last_d    = last_q;
    own_vld_d = own_vld_q;
    own_d     = own_q;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    case (state_q)
      S_IDLE: begin
        if (elig0 | elig1) begin
          win_d   = pick;
          we_d    = pick ? we1    : we0;
          addr_d  = pick ? addr1  : addr0;
          wdata_d = pick ? wdata1 : wdata0;
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        last_d = win_q;
        // Read data is captured at the edge that ends the access.
        if (!we_q) begin
          if (win_q) rdata1_d = mem_rdata;
          else       rdata0_d = mem_rdata;
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        // The served port's req in this cycle belongs to the finished
        // transaction, so no arbitration happens here.
        own_vld_d = win_q ? lock1 : lock0;
        own_d     = win_q;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Reset returns state to IDLE, so ack and mem_we drop without a clock.
  assign ack0      = (state_q == S_DONE) & ~win_q;
  assign ack1      = (state_q == S_DONE) &  win_q;
  assign mem_we    = (state_q == S_ACCESS) & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and random stimulus for dmem_arbiter against a
//   transaction-level model (grant cycle, memory image, lock owner).
// Outputs are compared on every falling edge.
module tb_dmem_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req, we, lock;
  logic [7:0] addr  [2];
  logic [3:0] wdata [2];
  logic [1:0] ack;
  logic [3:0] rdata [2];
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [3:0] mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_arbiter #(.AW(8), .DW(4)) dut (
    .clk(clk), .rst(rst),
    .req0(req[0]), .req1(req[1]),
    .we0(we[0]), .we1(we[1]),
    .addr0(addr[0]), .addr1(addr[1]),
    .wdata0(wdata[0]), .wdata1(wdata[1]),
    .lock0(lock[0]), .lock1(lock[1]),
    .ack0(ack[0]), .ack1(ack[1]),
    .rdata0(rdata[0]), .rdata1(rdata[1]),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  function automatic logic [3:0] pre(input int a);
    if (a == 8'h3A) return 4'h5;
    return 4'((a * 7 + 3) & 15);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory attached to the arbiter's pins.
  logic [3:0] mem [256];
  assign mem_rdata = mem[mem_addr];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = pre(i);
    forever begin
      @(posedge clk);
      if (mem_we) mem[mem_addr] = mem_wdata;
    end
  end

  // Reference model: a transaction granted in free cycle g accesses memory
  // in g+1 and acks in g+2.
  logic [3:0] ref_mem [256];
  bit         granted;
  int         g, cur, last_p, owner;
  logic       cur_we;
  logic [7:0] cur_addr, exp_addr;
  logic [3:0] cur_wd, exp_wd;
  logic [3:0] exp_rd [2];

  initial begin
    bit in_acc, in_done, e0, e1;
    int w;
    for (int i = 0; i < 256; i++) ref_mem[i] = pre(i);
    granted = 0; g = 0; cur = 0; last_p = 1; owner = -1;
    exp_addr = 0; exp_wd = 0; exp_rd[0] = 0; exp_rd[1] = 0;
    forever begin
      @(negedge clk);
      in_acc = 0; in_done = 0;
      if (rst) begin
        granted = 0; last_p = 1; owner = -1;
        exp_addr = 0; exp_wd = 0; exp_rd[0] = 0; exp_rd[1] = 0;
      end else begin
        in_acc  = granted && (cyc == g + 1);
        in_done = granted && (cyc == g + 2);
        if (in_done) begin
          if (cur_we) ref_mem[cur_addr] = cur_wd;
          else        exp_rd[cur] = ref_mem[cur_addr];
        end
      end
      chk("ack0",      ack[0],    (in_done && cur == 0) ? 1 : 0);
      chk("ack1",      ack[1],    (in_done && cur == 1) ? 1 : 0);
      chk("mem_we",    mem_we,    (in_acc && cur_we) ? 1 : 0);
      chk("mem_addr",  mem_addr,  exp_addr);
      chk("mem_wdata", mem_wdata, exp_wd);
      chk("rdata0",    rdata[0],  exp_rd[0]);
      chk("rdata1",    rdata[1],  exp_rd[1]);
      if (!rst) begin
        if (in_acc) last_p = cur;
        if (in_done) begin
          owner   = lock[cur] ? cur : -1;
          granted = 0;
        end else if (!granted) begin
          e0 = req[0] && (owner < 0 || owner == 0);
          e1 = req[1] && (owner < 0 || owner == 1);
          if (e0 || e1) begin
            if (e0 && e1) w = (last_p == 0) ? 1 : 0;
            else          w = e0 ? 0 : 1;
            granted  = 1; g = cyc; cur = w;
            cur_we   = we[w]; cur_addr = addr[w]; cur_wd = wdata[w];
            exp_addr = cur_addr; exp_wd = cur_wd;
          end
        end
      end
    end
  end

  // Observed ack log for ordering and spacing checks.
  int log_p [$];
  int log_c [$];
  always @(negedge clk) begin
    for (int p = 0; p < 2; p++)
      if (ack[p] === 1'b1) begin
        log_p.push_back(p);
        log_c.push_back(cyc);
      end
  end

  // Called just after a rising edge; returns just after the rising edge that
  // ends the ack cycle, with req dropped.
  task automatic do_txn(input int p, input logic w, input logic [7:0] a,
                        input logic [3:0] d, input logic l, output int lat);
    int t0;
    bit got;
    req[p] = 1'b1; we[p] = w; addr[p] = a; wdata[p] = d; lock[p] = l;
    t0 = cyc; got = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ack[p] === 1'b1) begin
        got = 1;
        break;
      end
    end
    chk("ack_seen", got, 1);
    lat = cyc - t0;
    @(posedge clk); #1;
    req[p] = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic rand_port(input int p);
    int lat, gap, sel;
    logic [7:0] a;
    for (int k = 0; k < 30; k++) begin
      gap = $urandom_range(0, 3);
      repeat (gap) begin @(posedge clk); #1; end
      sel = $urandom_range(0, 3);
      a = (sel == 0) ? 8'h00 : (sel == 1) ? 8'hFF : 8'($urandom_range(0, 255));
      do_txn(p, 1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)),
             (k < 29) && ($urandom_range(0, 3) == 0), lat);
    end
  endtask

  initial begin
    int lat;
    rst = 1'b1; req = 0; we = 0; lock = 0;
    addr[0] = 0; addr[1] = 0; wdata[0] = 0; wdata[1] = 0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_ack", ack, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_rdata0", rdata[0], 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single read.
    do_txn(0, 1'b0, 8'h3A, 4'h0, 1'b0, lat);
    chk("read_latency", lat, 2);
    chk("read_rdata0", rdata[0], 4'h5);
    chk("model_rd_3A", exp_rd[0], 4'h5);

    // Write then readback on port 1.
    do_txn(1, 1'b1, 8'hFF, 4'hC, 1'b0, lat);
    chk("write_latency", lat, 2);
    chk("write_keeps_rdata1", rdata[1], 4'h0);
    do_txn(1, 1'b0, 8'hFF, 4'h0, 1'b0, lat);
    chk("readback_rdata1", rdata[1], 4'hC);

    // Boundary addresses, cross-port, no aliasing.
    do_txn(0, 1'b1, 8'h00, 4'h9, 1'b0, lat);
    do_txn(1, 1'b1, 8'hFF, 4'h6, 1'b0, lat);
    do_txn(0, 1'b0, 8'hFF, 4'h0, 1'b0, lat);
    chk("bound_rd_ff", rdata[0], 4'h6);
    do_txn(1, 1'b0, 8'h00, 4'h0, 1'b0, lat);
    chk("bound_rd_00", rdata[1], 4'h9);

    // Contention after reset.
    do_reset();
    log_p.delete(); log_c.delete();
    fork
      begin int l0; for (int k = 0; k < 4; k++) do_txn(0, 1'b0, 8'h3A, 4'h0, 1'b0, l0); end
      begin int l1; for (int k = 0; k < 4; k++) do_txn(1, 1'b0, 8'hFF, 4'h0, 1'b0, l1); end
    join
    chk("cont_count", log_p.size(), 8);
    if (log_p.size() >= 8) begin
      for (int i = 0; i < 8; i++) chk("cont_order", log_p[i], i % 2);
      for (int i = 0; i < 7; i++) chk("cont_spacing", log_c[i+1] - log_c[i], 3);
    end

    // Lock: two port-0 transactions before port 1 is served.
    log_p.delete(); log_c.delete();
    fork
      begin
        int l0;
        do_txn(0, 1'b0, 8'h10, 4'h0, 1'b1, l0);
        do_txn(0, 1'b1, 8'h10, 4'hA, 1'b0, l0);
      end
      begin
        int l1;
        @(posedge clk); #1;
        do_txn(1, 1'b0, 8'h20, 4'h0, 1'b0, l1);
      end
    join
    chk("lock_count", log_p.size(), 3);
    if (log_p.size() >= 3) begin
      chk("lock_first", log_p[0], 0);
      chk("lock_second", log_p[1], 0);
      chk("lock_third", log_p[2], 1);
      chk("lock_p1_gap", log_c[2] - log_c[1], 3);
    end

    // Async reset in the middle of a port-0 write.
    log_p.delete(); log_c.delete();
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 8'h55; wdata[0] = 4'h3; lock[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_pre_we", mem_we, 1);
    #1 rst = 1'b1; req[0] = 1'b0;
    #1;
    chk("abort_mem_we", mem_we, 0);
    chk("abort_ack", ack, 0);
    chk("abort_mem_addr", mem_addr, 0);
    chk("abort_mem_wdata", mem_wdata, 0);
    chk("abort_rdata0", rdata[0], 0);
    chk("abort_rdata1", rdata[1], 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    fork
      begin int l0; do_txn(0, 1'b0, 8'h55, 4'h0, 1'b0, l0); end
      begin int l1; do_txn(1, 1'b0, 8'h00, 4'h0, 1'b0, l1); end
    join
    chk("post_rst_count", log_p.size(), 2);
    if (log_p.size() >= 2) begin
      chk("post_rst_first", log_p[0], 0);
      chk("post_rst_second", log_p[1], 1);
    end
    chk("post_rst_rd55", rdata[0], pre(8'h55));

    // Random traffic on both ports.
    fork
      rand_port(0);
      rand_port(1);
    join
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single data memory (256 x 4-bit, combinational read, write on clock edge) between two requesters, such as the CPU load/store path (port 0) and a loader/debug port (port 1). It grants the memory to one requester per transaction in round-robin order and drives the memory's `we`/`address`/`write_data` pins. It returns read data through per-port registers with a one-cycle `ack` pulse. A per-port `lock` keeps ownership across back-to-back transactions, for example an atomic read-modify-write.

## Interface
- `AW`, 8, address width (memory depth 2^AW)
- `DW`, 4, data width
- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `req0`/`req1`  in  1  transaction request; held high until this port's `ack`
- `we0`/`we1`  in  1  1 = write, 0 = read; stable while `req` high
- `addr0`/`addr1`  in  AW  target address; stable while `req` high
- `wdata0`/`wdata1`  in  DW  write data; stable while `req` high
- `lock0`/`lock1`  in  1  keep ownership after this transaction; sampled in DONE
- `ack0`/`ack1`  out  1  one-cycle completion pulse
- `rdata0`/`rdata1`  out  DW  registered read result; valid from `ack` onward, held until the next read on that port
- `mem_we`  out  1  to memory `we`
- `mem_addr`  out  AW  to memory `address`
- `mem_wdata`  out  DW  to memory `write_data`
- `mem_rdata`  in  DW  from memory `read_data` (combinational)

## Operation
- **States:**
  - IDLE: arbitrate.
  - ACCESS: drive memory for one cycle.
  - DONE: pulse `ack`, sample `lock`.
- **IDLE:**
  - If no eligible request, stay in IDLE.
  - Otherwise latch the winner index and its `we`/`addr`/`wdata` into internal registers, then go to ACCESS.
- **Eligibility:**
  - If a lock owner is recorded, only that port is eligible. The other port waits even if requesting.
  - With no owner, both ports are eligible.
- **Round-robin:**
  - When both ports are eligible, the port not served last wins.
  - `last` updates on every ACCESS.
- **ACCESS:**
  - `mem_addr`/`mem_wdata` come from the latched registers. `mem_we` = latched `we`.
  - A write lands on the memory at the edge ending ACCESS.
  - For a read, `mem_rdata` is captured into the winner's `rdata` at the same edge.
  - A write leaves that port's `rdata` unchanged.
  - Next state is DONE.
- **DONE:**
  - The winner's `ack` is high.
  - If the winner's `lock` = 1, record it as lock owner; else clear the owner.
  - Next state is IDLE.
  - The acked port's `req` seen in DONE belongs to the finished transaction and is ignored. The requester drops or re-presents `req` from the next cycle.
- **Outside ACCESS:**
  - `mem_we` = 0.
  - `mem_addr`/`mem_wdata` hold their last values.
- **Lock handling:**
  - A lock owner that drops `req` while locked keeps ownership indefinitely.
  - Ownership releases only by completing a transaction with `lock` = 0, or by reset.
- **Unrequested ports:** the non-winning port's `ack` and `rdata` are untouched.

## Timing
- **Latency:** `req` first seen high in IDLE at cycle N gives ACCESS at N+1, `ack` at N+2.
  - Read data is valid at N+2.
  - Memory write is complete at the N+1→N+2 edge.
- **Throughput:** one transaction per 3 cycles. Re-request at N+3 is arbitrated at N+3.
- **Simultaneous requests:** both requests high in IDLE are served in alternate transactions. The loser is served in its next IDLE window at the latest.
  - Worst-case wait with no lock is 3 cycles extra.
- **Reset:** `rst` high forces immediately, with no clock needed:
  - state = IDLE, `last` = 1 (port 0 wins the first tie), lock owner = none.
  - `ack0` = `ack1` = 0, `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0, `rdata0` = `rdata1` = 0.
- **Reset mid-operation:**
  - Reset asserted during ACCESS aborts the access: `mem_we` drops asynchronously.
  - Whether a write landed depends on edge ordering and is unspecified.
  - No `ack` is produced.
  - The requester must re-issue after reset.
- **Address range:** all 2^AW addresses are legal. There is no wrap or range check.

## Test plan
- **Single read:** preload mem[0x3A] = 0x5, `req0` = 1, `we0` = 0, `addr0` = 0x3A → `mem_addr` = 0x3A at N+1, `ack0` = 1 and `rdata0` = 0x5 at N+2, `mem_we` never high.
- **Write then readback:** port 1 writes 0xC to 0xFF → `mem_we` = 1 only at N+1, `ack1` at N+2, `rdata1` unchanged. A following port-1 read of 0xFF gives `rdata1` = 0xC.
- **Contention:** both ports request reads continuously after reset → grants alternate 0,1,0,1. `ack` spacing is 3 cycles, each port acked every 6 cycles, never both in the same cycle.
- **Lock:**
  - Port 0 reads 0x10 with `lock0` = 1 while `req1` is held high. Port 0 then writes 0x10 with `lock0` = 0.
  - Required: two port-0 transactions complete before any port-1 grant, and port 1 is granted in the IDLE after the second `ack0`.
- **Async reset:** assert `rst` mid-ACCESS of a port-0 write → `mem_we` = 0, all outputs 0 immediately, no `ack0`. After release, a tie grants port 0 first.
- **Boundary addresses:** write/read 0x00 and 0xFF on both ports → data round-trips correctly, with no aliasing between 0x00 and 0xFF.
